// File: rtl/ifu_cache_sa.sv
`timescale 1ns/1ps
// ifu_cache_sa: N-way set-associative instruction cache with per-set tree-PLRU
// replacement. One outstanding request; hits answer in one cycle, misses
// go through a mem-side request/refill handshake.
// Optional feature macro: IFU_CACHE_FLUSH_EN (adds flushIn, invalidates all lines).
module ifu_cache_sa #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 4,
    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
    localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Rst_n,
`ifdef IFU_CACHE_FLUSH_EN
    input  logic                   flushIn,
`endif
    input  logic                   cpu_reqValidIn,
    input  logic [ADDR_WIDTH-1:0]  cpu_reqAddrIn,
    output logic                   cpu_reqReadyOut,
    output logic                   cpu_rspValidOut,
    output logic [ADDR_WIDTH-1:0]  cpu_rspAddrOut,
    output logic [LINE_WIDTH-1:0]  cpu_rspInsLineOut,
    output logic                   mem_reqValidOut,
    output logic [LADDR_WIDTH-1:0] mem_reqTagOut,
    input  logic                   mem_reqReadyIn,
    input  logic                   mem_rspValidIn,
    input  logic [LADDR_WIDTH-1:0] mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0]  mem_rspInsLineIn,
    output logic                   hitStatusOut,
    output logic [NUM_WAYS-2:0]    plruTreeOut
);

    localparam int SET_WIDTH = $clog2(NUM_SETS);
    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH - SET_WIDTH;
    localparam int SIDX_W    = (SET_WIDTH > 0) ? SET_WIDTH : 1;
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int TREE_W    = NUM_WAYS - 1;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, FILL} state_t;

    state_t state, state_next;

    logic [TAG_WIDTH-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [TREE_W-1:0]     plru_q  [NUM_SETS];

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0] fill_line;
    logic                  flush_pend;
    logic                  flush_req;

    logic                  rsp_valid;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [LINE_WIDTH-1:0] rsp_line;
    logic                  hit_status;
    logic [TREE_W-1:0]     plru_out;

    logic [SIDX_W-1:0]     lk_set;
    logic [TAG_WIDTH-1:0]  lk_tag;
    logic                  lk_match;
    logic [WAY_W-1:0]      lk_way;
    logic                  lookup_hit;
    logic                  accept;
    logic                  mem_req_valid;

    logic [SIDX_W-1:0]     req_set;
    logic [WAY_W-1:0]      vic_way;
    logic                  vic_found;
    logic                  rsp_match;

    function automatic logic [SIDX_W-1:0] set_of(input logic [ADDR_WIDTH-1:0] a);
        logic [LADDR_WIDTH-1:0] la;
        la = a[ADDR_WIDTH-1:OFFSET_WIDTH];
        return (SET_WIDTH == 0) ? '0 : la[SIDX_W-1:0];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    // Every node on the path to the accessed way is turned to point away from it.
    function automatic logic [TREE_W-1:0] plru_update(input logic [TREE_W-1:0] tree,
                                                      input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] t;
        logic              dir;
        int                node;
        t    = tree;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = way[WAY_W-1-l];
            t[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return t;
    endfunction

    // Following the bits from the root leads to the pseudo-least-recently-used way.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] tree);
        logic [WAY_W-1:0] w;
        logic             dir;
        int               node;
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir            = tree[node];
            w[WAY_W-1-l]   = dir;
            node           = 2 * node + 1 + int'(dir);
        end
        return w;
    endfunction

`ifdef IFU_CACHE_FLUSH_EN
    assign flush_req = flushIn;
`else
    assign flush_req = 1'b0;
`endif

    assign req_set   = set_of(req_addr);
    assign rsp_match = (mem_rspTagIn == req_addr[ADDR_WIDTH-1:OFFSET_WIDTH]);

    // Tag compare across all ways of the set addressed by the incoming request.
    always_comb begin
        lk_set   = set_of(cpu_reqAddrIn);
        lk_tag   = tag_of(cpu_reqAddrIn);
        lk_match = 1'b0;
        lk_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                lk_match = 1'b1;
                lk_way   = WAY_W'(w);
            end
        end
    end

    // Victim for the pending miss: lowest invalid way first, else the PLRU way.
    always_comb begin
        vic_way   = plru_victim(plru_q[req_set]);
        vic_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[req_set][w] && !vic_found) begin
                vic_way   = WAY_W'(w);
                vic_found = 1'b1;
            end
        end
    end

    // Next-state and handshake decode; a flush in the accept cycle forces a miss.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        lookup_hit    = lk_match && !flush_req;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_reqValidIn) begin
                    accept = 1'b1;
                    if (!lookup_hit) begin
                        state_next = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_reqReadyIn) begin
                    state_next = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_rspValidIn && rsp_match) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control, response, valid and PLRU state; reset invalidates every line.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            req_addr   <= '0;
            fill_line  <= '0;
            flush_pend <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_line   <= '0;
            hit_status <= 1'b0;
            plru_out   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr   <= cpu_reqAddrIn;
                        hit_status <= lookup_hit;
                        if (lookup_hit) begin
                            rsp_valid      <= 1'b1;
                            rsp_addr       <= cpu_reqAddrIn;
                            rsp_line       <= data_q[lk_set][lk_way];
                            plru_q[lk_set] <= plru_update(plru_q[lk_set], lk_way);
                            plru_out       <= plru_update(plru_q[lk_set], lk_way);
                        end
                    end
                    if (flush_req) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            valid_q[s] <= '0;
                            plru_q[s]  <= '0;
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush_req) begin
                        flush_pend <= 1'b1;
                    end
                end
                MISS_WAIT: begin
                    if (flush_req) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_rspValidIn && rsp_match) begin
                        fill_line <= mem_rspInsLineIn;
                    end
                end
                FILL: begin
                    valid_q[req_set][vic_way] <= 1'b1;
                    plru_q[req_set]           <= plru_update(plru_q[req_set], vic_way);
                    plru_out                  <= plru_update(plru_q[req_set], vic_way);
                    rsp_valid                 <= 1'b1;
                    rsp_addr                  <= req_addr;
                    rsp_line                  <= fill_line;
                    flush_pend                <= 1'b0;
                    if (flush_pend || flush_req) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            valid_q[s] <= '0;
                            plru_q[s]  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage are written only by a refill; contents are qualified by valid.
    always_ff @(posedge Clock) begin
        if (state == FILL) begin
            tag_q[req_set][vic_way]  <= tag_of(req_addr);
            data_q[req_set][vic_way] <= fill_line;
        end
    end

    assign cpu_reqReadyOut   = (state == IDLE);
    assign cpu_rspValidOut   = rsp_valid;
    assign cpu_rspAddrOut    = rsp_addr;
    assign cpu_rspInsLineOut = rsp_line;
    assign mem_reqValidOut   = mem_req_valid;
    assign mem_reqTagOut     = req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign hitStatusOut      = hit_status;
    assign plruTreeOut       = plru_out;

endmodule
